// File: rtl/bike_pkg.sv
// bike_pkg: shared constants and helpers for the bicycle computer
package bike_pkg;
   localparam int F_CLK_DEF     = 2048;
   localparam int KMH_NUM       = 36;
   localparam int KMH_DEN       = 1000;
   localparam int SPEED_MAX_DEF = 99;
   function automatic int clog2(input longint unsigned v);
      int r;
      r = 0;
      while ((64'd1 << r) < v) r++;
      return r;
   endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring unsigned divider, one quotient bit per cycle
module seq_divider import bike_pkg::*; #(
   parameter int NUM_W = 25,
   parameter int DEN_W = 26
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [NUM_W-1:0] num,
   input  logic [DEN_W-1:0] den,
   output logic             busy,
   output logic             done,
   output logic [NUM_W-1:0] quo
);
   localparam int CNT_W = clog2(NUM_W + 1);
   logic [DEN_W-1:0] rem, den_r;
   logic [CNT_W-1:0] cnt;
   logic [DEN_W:0]   shifted, trial;
   // trial subtraction of the divisor from the partial remainder
   always_comb begin
      shifted = {rem, quo[NUM_W-1]};
      trial   = shifted - {1'b0, den_r};
   end
   // quo starts as the dividend and fills with quotient bits from the right
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         busy  <= 1'b0;
         done  <= 1'b0;
         cnt   <= '0;
         rem   <= '0;
         den_r <= '0;
         quo   <= '0;
      end else begin
         done <= 1'b0;
         if (abort) busy <= 1'b0;
         else if (start && !busy) begin
            busy  <= 1'b1;
            cnt   <= CNT_W'(NUM_W);
            rem   <= '0;
            den_r <= den;
            quo   <= num;
         end else if (busy) begin
            rem <= trial[DEN_W] ? shifted[DEN_W-1:0] : trial[DEN_W-1:0];
            quo <= {quo[NUM_W-2:0], ~trial[DEN_W]};
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
endmodule

// File: rtl/reed_speed_meter.sv
// reed_speed_meter: reed conditioning, period measurement and km/h speed tracking
module reed_speed_meter import bike_pkg::*; #(
   parameter int F_CLK     = F_CLK_DEF,
   parameter int CIRC_W    = 8,
   parameter int PER_W     = 16,
   parameter int SPEED_W   = 8,
   parameter int SPEED_MAX = SPEED_MAX_DEF,
   parameter int MIN_SPEED = 3,
   parameter int DEBOUNCE  = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               reed,
   input  logic [CIRC_W-1:0]  circ,
   output logic [SPEED_W-1:0] speed,
   output logic               speed_valid,
   output logic [SPEED_W-1:0] max_speed,
   output logic               moving,
   output logic [15:0]        rev_count
);
   localparam longint K_NUM = longint'(F_CLK) * KMH_NUM;
   localparam int NUM_W  = CIRC_W + clog2(K_NUM);
   localparam int DEN_W  = PER_W + clog2(KMH_DEN);
   localparam int CMP_W  = NUM_W + DEN_W;
   localparam int LOCK_W = clog2(DEBOUNCE + 2);
   logic               s1, s2, s3, rise, acc, tmo, start, pend_v;
   logic               d_busy, d_done;
   logic [LOCK_W-1:0]  lock;
   logic [PER_W-1:0]   cnt, pend;
   logic [NUM_W-1:0]   num, d_quo;
   logic [DEN_W-1:0]   den;
   logic [SPEED_W-1:0] res;
   // edge acceptance, timeout test, divider launch and result clamp
   always_comb begin
      rise  = s2 & ~s3;
      acc   = rise & (lock == '0) & ~clear;
      num   = NUM_W'(circ) * NUM_W'(K_NUM);
      tmo   = moving & ~acc & (CMP_W'(cnt) * CMP_W'(MIN_SPEED * KMH_DEN) > CMP_W'(num));
      start = ~clear & ~tmo & ~d_busy & (pend_v | (acc & moving));
      den   = DEN_W'(pend_v ? pend : cnt) * DEN_W'(KMH_DEN);
      res   = (d_quo > NUM_W'(SPEED_MAX)) ? SPEED_W'(SPEED_MAX) : d_quo[SPEED_W-1:0];
   end
   // two-flop synchroniser plus edge-history flop; trip clear leaves it running
   always_ff @(posedge clock or negedge reset)
      if (!reset) {s1, s2, s3} <= '0;
      else {s1, s2, s3} <= {reed, s1, s2};
   // lockout, period counter, pending buffer and speed/max/revolution tracking
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         lock        <= '0;
         cnt         <= '0;
         pend        <= '0;
         pend_v      <= 1'b0;
         moving      <= 1'b0;
         rev_count   <= '0;
         speed       <= '0;
         speed_valid <= 1'b0;
         max_speed   <= '0;
      end else if (clear) begin
         lock        <= '0;
         cnt         <= '0;
         pend        <= '0;
         pend_v      <= 1'b0;
         moving      <= 1'b0;
         rev_count   <= '0;
         speed       <= '0;
         speed_valid <= 1'b0;
         max_speed   <= '0;
      end else begin
         lock        <= acc ? LOCK_W'(DEBOUNCE) : lock - LOCK_W'(lock != '0);
         speed_valid <= d_done & ~tmo;
         if (acc) begin
            rev_count <= rev_count + 16'd1;
            moving    <= 1'b1;
            cnt       <= PER_W'(1);
         end else if (tmo) begin
            moving <= 1'b0;
            cnt    <= '0;
         end else if (moving && cnt != '1) cnt <= cnt + PER_W'(1);
         if (tmo) pend_v <= 1'b0;
         else if (acc && moving && (d_busy || pend_v)) begin
            pend   <= cnt;
            pend_v <= 1'b1;
         end else if (start) pend_v <= 1'b0;
         if (tmo) speed <= '0;
         else if (d_done) begin
            speed <= res;
            if (res > max_speed) max_speed <= res;
         end
      end
   seq_divider #(.NUM_W(NUM_W), .DEN_W(DEN_W)) u_div (
      .clock (clock),
      .reset (reset),
      .start (start),
      .abort (clear | tmo),
      .num   (num),
      .den   (den),
      .busy  (d_busy),
      .done  (d_done),
      .quo   (d_quo)
   );
endmodule
